// File: rtl/out_port_uart.sv
// out_port_uart
// Output-port peripheral on the CPU's 4-bit data bus. Nibbles written with
// `ld` are paired low-then-high into bytes. Each byte is queued in a small
// FIFO and sent as an 8N1 serial frame on `txd`. A status nibble is returned
// on `y` while `rd` is asserted.
//
// Parameters
//   CLK_DIV     clk cycles per serial bit (2..65535)
//   FIFO_DEPTH  byte FIFO depth (power of 2, >= 2)
//
// Ports
//   clk   in   system clock, all state on posedge
//   rst   in   synchronous reset, active-high
//   ld    in   nibble write strobe, captures x at the edge
//   x     in   [3:0] data nibble
//   rd    in   status read strobe, also clears the sticky overflow flag
//   y     out  [3:0] status {hi_pending, overflow, full, empty}, 0 when rd=0
//   txd   out  registered serial output, idle high
//   busy  out  FIFO non-empty or frame in progress
module out_port_uart #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] x,
    input  logic       rd,
    output logic [3:0] y,
    output logic       txd,
    output logic       busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // control state
    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_idx;
    logic             hi_pend;
    logic             ovf;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // datapath state (not reset)
    logic [3:0]       lo_nib;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [7:0]       shift;

    logic full;
    logic empty;
    logic push_req;
    logic push_ok;
    logic pop;
    logic bit_done;

    always_comb begin
        full     = (count == CNT_FULL);
        empty    = (count == '0);
        push_req = ld & hi_pend;
        // A full FIFO rejects the byte even if a pop frees a slot this edge.
        push_ok  = push_req & ~full;
        pop      = (state == IDLE) & ~empty;
        bit_done = (div_cnt == '0);
    end

    assign busy = (state != IDLE) | ~empty;
    assign y    = rd ? {hi_pend, ovf, full, empty} : 4'b0000;

    // Nibble phase, FIFO pointers/count and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_pend <= 1'b0;
            ovf     <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (ld)
                hi_pend <= ~hi_pend;
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A fresh overflow beats a clearing read on the same edge.
            if (push_req & full)
                ovf <= 1'b1;
            else if (rd)
                ovf <= 1'b0;
        end
    end

    // Low-nibble holding register and FIFO storage.
    always_ff @(posedge clk) begin
        if (ld & ~hi_pend)
            lo_nib <= x;
        if (push_ok)
            mem[wr_ptr] <= {x, lo_nib};
    end

    // Shift register: loaded on pop, shifted right at the end of each data bit.
    always_ff @(posedge clk) begin
        if (pop)
            shift <= mem[rd_ptr];
        else if (state == DATA && bit_done)
            shift <= {1'b0, shift[7:1]};
    end

    // TX framing FSM. txd is registered and updated together with the state,
    // so it changes on the same edge the FSM enters each bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        state   <= START;
                        div_cnt <= DIV_LAST;
                        txd     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        div_cnt <= DIV_LAST;
                        bit_idx <= '0;
                        txd     <= shift[0];
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        div_cnt <= DIV_LAST;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            // shift[1] becomes shift[0] on this same edge
                            txd     <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                STOP: begin
                    txd <= 1'b1;
                    if (bit_done)
                        state <= IDLE;
                    else
                        div_cnt <= div_cnt - DIV_W'(1);
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
